// File: rtl/add_serial_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : add_serial_ctrl
//  Purpose  : Sequencer that time-multiplexes one external SLICE-bit ripple
//             adder slice to produce a WIDTH-bit sum over WIDTH/SLICE cycles.
//             Operands arrive over a valid/ready handshake, and the result
//             leaves over a second valid/ready handshake.
//  Ports    : clk, rst_n          - clock / asynchronous active-low reset
//             inValid/inReady     - operand handshake (a, b, carryIn)
//             abort               - synchronous cancel, returns to IDLE
//             outValid/outReady   - result handshake (sum, carryOut)
//             sliceA/B/Cin        - drive the external slice inputs
//             sliceSum/Cout       - results returned by the external slice
//             subtract            - only present with ADD_SERIAL_SUB_EN
//  Options  : ADD_SERIAL_SUB_EN   - adds the subtract input (a - b)
//  Revision : 1.0  initial release
// ============================================================================
module add_serial_ctrl #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    input  logic             abort,
`ifdef ADD_SERIAL_SUB_EN
    input  logic             subtract,
`endif
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic [SLICE-1:0] sliceA,
    output logic [SLICE-1:0] sliceB,
    output logic             sliceCin,
    input  logic [SLICE-1:0] sliceSum,
    input  logic             sliceCout
);

    localparam int N    = WIDTH / SLICE;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] c_LAST = IDXW'(N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;

    // A partial top slice would silently drop bits, so refuse to build.
    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_width
            $error("add_serial_ctrl: WIDTH must be an integer multiple of SLICE");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic [WIDTH-1:0] w_opB_in;
    logic             w_cin_in;

    // Subtraction is a + ~b + 1; carryIn is ignored while subtracting.
`ifdef ADD_SERIAL_SUB_EN
    assign w_opB_in = subtract ? ~b   : b;
    assign w_cin_in = subtract ? 1'b1 : carryIn;
`else
    assign w_opB_in = b;
    assign w_cin_in = carryIn;
`endif

    // abort beats a simultaneous operand offer.
    assign w_accept = (r_state == c_IDLE) && inValid && !abort;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (inValid)          w_next_state = c_RUN;
                c_RUN:   if (r_idx == c_LAST)  w_next_state = c_HOLD;
                c_HOLD:  if (outReady)         w_next_state = c_IDLE;
                default:                       w_next_state = c_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    // Slice inputs are held at zero outside RUN so the slice stays quiet.
    always_comb begin
        inReady  = (r_state == c_IDLE);
        outValid = (r_state == c_HOLD);
        sliceA   = '0;
        sliceB   = '0;
        sliceCin = 1'b0;
        if (r_state == c_RUN) begin
            sliceCin = r_carry;
            for (int i = 0; i < N; i++) begin
                if (r_idx == IDXW'(i)) begin
                    sliceA = r_opA[i*SLICE +: SLICE];
                    sliceB = r_opB[i*SLICE +: SLICE];
                end
            end
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_opA   <= '0;
            r_opB   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_opA   <= a;
            r_opB   <= w_opB_in;
            r_carry <= w_cin_in;
            r_idx   <= '0;
        end else if (abort) begin
            // Partial sum is left as-is; only the sequencer is rewound.
            r_idx <= '0;
        end else if (r_state == c_RUN) begin
            for (int i = 0; i < N; i++) begin
                if (r_idx == IDXW'(i)) begin
                    r_sum[i*SLICE +: SLICE] <= sliceSum;
                end
            end
            // Carry out of this slice feeds the next slice's carry-in.
            r_carry <= sliceCout;
            if (r_idx == c_LAST) begin
                r_cout <= sliceCout;
                r_idx  <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign sum      = r_sum;
    assign carryOut = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_add_serial_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_add_serial_ctrl
//  Purpose  : Self-checking bench for add_serial_ctrl. Models the external
//             4-bit slice, drives a vector table plus corner-case sequences,
//             and compares results through an expected-result queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_serial_ctrl;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             inValid  = 1'b0;
    logic             inReady;
    logic [WIDTH-1:0] a        = '0;
    logic [WIDTH-1:0] b        = '0;
    logic             carryIn  = 1'b0;
    logic             abort    = 1'b0;
    logic             subtract = 1'b0;
    logic             outValid;
    logic             outReady = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             carryOut;
    logic [SLICE-1:0] sliceA;
    logic [SLICE-1:0] sliceB;
    logic             sliceCin;
    logic [SLICE-1:0] sliceSum;
    logic             sliceCout;

    add_serial_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inValid   (inValid),
        .inReady   (inReady),
        .a         (a),
        .b         (b),
        .carryIn   (carryIn),
        .abort     (abort),
`ifdef ADD_SERIAL_SUB_EN
        .subtract  (subtract),
`endif
        .outValid  (outValid),
        .outReady  (outReady),
        .sum       (sum),
        .carryOut  (carryOut),
        .sliceA    (sliceA),
        .sliceB    (sliceB),
        .sliceCin  (sliceCin),
        .sliceSum  (sliceSum),
        .sliceCout (sliceCout)
    );

    always #5 clk = ~clk;

    // Behavioural model of the external add_4_bit slice.
    assign {sliceCout, sliceSum} = {1'b0, sliceA} + {1'b0, sliceB} + {4'b0, sliceCin};

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             co;
    } res_t;
    res_t sb_q[$];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] s;
        logic             co;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Result monitor: a handshake completes on the next edge when both
    // outValid and outReady are high.
    always @(negedge clk) begin
        #1;
        if (rst_n && outValid && outReady) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got result 0x%0h with none pending (expected no result)", sum);
            end else begin
                res_t e;
                e = sb_q.pop_front();
                chk("sb_sum", sum, e.s);
                chk("sb_cout", carryOut, e.co);
            end
        end
    end

    // Offer operands at a negedge; returns at the first negedge in RUN.
    task automatic present(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic cv, input logic sv);
        int n;
        n = 0;
        while (!inReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("inReady_wait", inReady, 1);
        a = av; b = bv; carryIn = cv; subtract = sv; inValid = 1'b1;
        @(negedge clk);
        // Scramble inputs: the DUT must be working from its own copies.
        inValid  = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        carryIn  = 1'($urandom);
        subtract = 1'($urandom);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input logic sv,
                         input logic [WIDTH-1:0] es, input logic eco, input logic hold5);
        logic [WIDTH-1:0] bb;
        logic             c0;
        logic [WIDTH-1:0] mask;
        logic [WIDTH:0]   lo;
        bb = sv ? ~bv : bv;
        c0 = sv ? 1'b1 : cv;
        sb_q.push_back('{s: es, co: eco});
        outReady = !hold5;
        present(av, bv, cv, sv);
        for (int i = 0; i < N; i++) begin
            mask = (WIDTH'(1) << (SLICE * i)) - WIDTH'(1);
            lo   = {1'b0, av & mask} + {1'b0, bb & mask} + {{WIDTH{1'b0}}, c0};
            chk("run_outValid", outValid, 0);
            chk("run_inReady", inReady, 0);
            chk("sliceA", sliceA, av[i*SLICE +: SLICE]);
            chk("sliceB", sliceB, bb[i*SLICE +: SLICE]);
            chk("sliceCin", sliceCin, lo[i*SLICE]);
            @(negedge clk);
        end
        chk("latency_outValid", outValid, 1);
        if (hold5) begin
            repeat (5) begin
                chk("hold_outValid", outValid, 1);
                chk("hold_sum", sum, es);
                chk("hold_cout", carryOut, eco);
                chk("hold_sliceA_idle", sliceA, 0);
                @(negedge clk);
            end
            outReady = 1'b1;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        chk("post_inReady", inReady, 1);
        chk("post_outValid", outValid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0};
        vecs[5] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

        // Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_inReady", inReady, 1);
        chk("rst_outValid", outValid, 0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", carryOut, 0);
        chk("rst_sliceA", sliceA, 0);

        // Vector table
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].s, vecs[i].co, 1'b0);
        end

        // Back-pressure: result held for 5 cycles
        do_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b1);

        // Abort at RUN step 2
        outReady = 1'b1;
        present(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_inReady", inReady, 1);
        chk("abort_outValid", outValid, 0);
        repeat (N + 2) begin
            @(negedge clk);
            chk("abort_no_valid", outValid, 0);
        end

        // abort together with inValid in IDLE: not accepted
        a = 16'h7777; b = 16'h1111; carryIn = 1'b0;
        inValid = 1'b1;
        abort   = 1'b1;
        @(negedge clk);
        chk("abort_blocks_accept", inReady, 1);
        inValid = 1'b0;
        abort   = 1'b0;
        do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

        // Reset mid-RUN
        present(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_inReady", inReady, 1);
        chk("midrst_outValid", outValid, 0);
        chk("midrst_sum", sum, 16'h0000);
        chk("midrst_cout", carryOut, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0);

`ifdef ADD_SERIAL_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add_serial_ctrl.md
Name: add_serial_ctrl

Overview:
- Controller that time-multiplexes one SLICE-bit ripple adder slice (an external add_4_bit instance) to perform a WIDTH-bit add over WIDTH/SLICE cycles.
- Trades latency for area against the parallel 16-bit adder. Sits between a requester with a valid/ready operand interface and a consumer with a valid/ready result interface.
- Owns operand/result registers, carry chaining between slices and the sequencing FSM.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, width of the external adder slice.
- N (localparam), WIDTH/SLICE, number of slice steps.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- inValid  input  1  operands a, b, carryIn valid
- inReady  output  1  controller can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carryIn  input  1  carry into bit 0
- abort  input  1  synchronous cancel of the current operation
- outValid  output  1  sum/carryOut valid
- outReady  input  1  consumer accepts result
- sum  output  WIDTH  registered result
- carryOut  output  1  registered carry out of MSB
- sliceA  output  SLICE  to slice .a
- sliceB  output  SLICE  to slice .b
- sliceCin  output  1  to slice .carryIn
- sliceSum  input  SLICE  from slice .sum
- sliceCout  input  1  from slice .carryOut

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, sum=0, carryOut=0, outValid=0, carry register=0, operand registers=0. inReady is 1 after reset.
- States:
  - IDLE: inReady=1, outValid=0. On inValid & inReady & !abort: capture a, b, carryIn into opA, opB and the carry register; idx=0; go to RUN.
  - RUN: inReady=0, outValid=0. sliceA=opA[idx*SLICE +: SLICE], sliceB=opB[idx*SLICE +: SLICE], sliceCin=carry register. Slice is purely combinational.
    - Each edge: sum[idx*SLICE +: SLICE] <= sliceSum; carry register <= sliceCout; idx <= idx+1.
    - When idx==N-1: carryOut <= sliceCout, idx <= 0, go to HOLD.
  - HOLD: outValid=1, inReady=0. sum and carryOut are stable. On outReady, go to IDLE and drop outValid.
- Slice ports outside RUN: sliceA=0, sliceB=0, sliceCin=0.
- Latency: if operands are accepted on edge k, outValid is high from edge k+N. Default is 4 cycles.
- Throughput: one result per N+2 cycles when outReady is held high. No back-to-back accept in the HOLD→IDLE cycle.
- Arithmetic: {carryOut,sum} = a + b + carryIn, modulo 2^(WIDTH+1). Unused upper bits do not exist because WIDTH % SLICE == 0. A configuration with WIDTH % SLICE != 0 must be rejected at elaboration.
- abort (any state): next state is IDLE, idx=0, outValid=0. The sum register keeps its partial contents; do not rely on it.
- abort with inValid in IDLE: abort wins and the operand is not accepted (inReady is still 1, so the requester must re-present).
- a, b and carryIn changing during RUN have no effect because the operands are registered.
- Reset asserted mid-RUN or mid-HOLD: immediate return to reset values. The result is lost.
- outReady while not in HOLD: ignored.

Optional Feature:
- Macro: ADD_SERIAL_SUB_EN.
- Defined:
  - Adds port "subtract" (input, 1), captured with the operands on accept.
  - When subtract=1, opB is stored as ~b and the initial carry register is forced to 1, so the result is a - b. carryIn is ignored. carryOut=1 means no borrow.
  - When subtract=0, the block behaves as the add-only build.
- Not defined: the port is absent and the block always adds.

Test Plan:
- Reset: hold rst_n low, then release → inReady=1, outValid=0, sum=0x0000, carryOut=0.
- Accept a=0x1234, b=0x4321, carryIn=0 → after 4 cycles outValid=1, sum=0x5555, carryOut=0. Per-cycle sliceA sequence is 4, 3, 2, 1.
- a=0xFFFF, b=0x0001, carryIn=0 → sum=0x0000, carryOut=1. sliceCin is 0, 1, 1, 1 across the steps.
- a=0x00FF, b=0x0000, carryIn=1 → sum=0x0100, carryOut=0. With outReady held low for 5 cycles, outValid and sum stay stable; outReady=1 then returns the FSM to IDLE.
- Back-pressure and abort: abort at RUN step 2 → IDLE next cycle with outValid never asserted. inValid together with abort in IDLE → not accepted; the next operand pair is computed correctly.
- With ADD_SERIAL_SUB_EN defined: subtract=1, a=0x0005, b=0x0007 → sum=0xFFFE, carryOut=0. Then a=0x0007, b=0x0005 → sum=0x0002, carryOut=1.
